// File: rtl/gx_reset_pkg.sv
// Shared types and default counts for the transceiver reset sequencer.
package gx_reset_pkg;

   typedef enum logic [1:0] {
      TX_PD     = 2'd0,
      TX_WAIT   = 2'd1,
      TX_ANALOG = 2'd2,
      TX_READY  = 2'd3
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_RST   = 2'd0,
      RX_CAL   = 2'd1,
      RX_LTD   = 2'd2,
      RX_READY = 2'd3
   } rx_state_t;

   localparam int DEF_PLL_PD_CNT = 10;
   localparam int DEF_ANALOG_CNT = 4;
   localparam int DEF_TX_DIG_CNT = 8;
   localparam int DEF_LTD_CNT    = 16;

   function automatic int cnt_w(input int max_cnt);
      return $clog2(max_cnt) + 1;
   endfunction

endpackage

// File: rtl/gx_reset_if.sv
// PHY-facing reset/status bundle for one transceiver channel group.
interface gx_reset_if #(
   parameter int CH_N = 1
);
   logic            pll_locked_i;
   logic            pll_cal_busy_i;
   logic            pll_powerdown_o;
   logic [CH_N-1:0] gx_tx_cal_busy_i;
   logic [CH_N-1:0] gx_rx_cal_busy_i;
   logic [CH_N-1:0] gx_rx_is_lockedtodata_i;
   logic [CH_N-1:0] gx_tx_analogreset_o;
   logic [CH_N-1:0] gx_tx_digitalreset_o;
   logic [CH_N-1:0] gx_rx_analogreset_o;
   logic [CH_N-1:0] gx_rx_digitalreset_o;
   logic            tx_ready_o;
   logic [CH_N-1:0] rx_ready_o;

   modport master (
      input  pll_locked_i, pll_cal_busy_i, gx_tx_cal_busy_i, gx_rx_cal_busy_i,
             gx_rx_is_lockedtodata_i,
      output pll_powerdown_o, gx_tx_analogreset_o, gx_tx_digitalreset_o,
             gx_rx_analogreset_o, gx_rx_digitalreset_o, tx_ready_o, rx_ready_o
   );

   modport slave (
      output pll_locked_i, pll_cal_busy_i, gx_tx_cal_busy_i, gx_rx_cal_busy_i,
             gx_rx_is_lockedtodata_i,
      input  pll_powerdown_o, gx_tx_analogreset_o, gx_tx_digitalreset_o,
             gx_rx_analogreset_o, gx_rx_digitalreset_o, tx_ready_o, rx_ready_o
   );
endinterface

// File: rtl/gx_rx_reset_fsm.sv
// Per-lane RX reset sequencer; inputs are already synchronised to clk_50m.
//  state    | meaning
//  RX_RST   | analog+digital held, minimum analog hold timer running
//  RX_CAL   | analog+digital held, waiting for rx calibration to finish
//  RX_LTD   | analog released, waiting for LTD_CNT consecutive lock-to-data samples
//  RX_READY | lane out of reset
module gx_rx_reset_fsm
   import gx_reset_pkg::*;
#(
   parameter int ANALOG_CNT = DEF_ANALOG_CNT,
   parameter int LTD_CNT    = DEF_LTD_CNT
) (
   input  logic clk_50m,
   input  logic io_nreset_i,
   input  logic rx_cal_busy,
   input  logic rx_ltd,
   output logic rx_analogreset,
   output logic rx_digitalreset,
   output logic rx_ready
);
   localparam int CW = cnt_w((ANALOG_CNT > LTD_CNT) ? ANALOG_CNT : LTD_CNT);
   localparam logic [CW-1:0] ANA_LOAD = CW'(ANALOG_CNT - 1);
   localparam logic [CW-1:0] LTD_LOAD = CW'(LTD_CNT - 1);

   rx_state_t       state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;

   always_ff @(posedge clk_50m) begin
      if (!io_nreset_i) begin
         state           <= RX_RST;
         cnt             <= ANA_LOAD;
         rx_analogreset  <= 1'b1;
         rx_digitalreset <= 1'b1;
         rx_ready        <= 1'b0;
      end else begin
         state           <= state_nx;
         cnt             <= cnt_nx;
         rx_analogreset  <= (state_nx == RX_RST) || (state_nx == RX_CAL);
         rx_digitalreset <= (state_nx != RX_READY);
         rx_ready        <= (state_nx == RX_READY);
      end
   end

   // cal_busy is tested before lock loss so it wins when both arrive together
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         RX_RST: begin
            if (cnt == '0) state_nx = RX_CAL;
            else           cnt_nx   = cnt - 1'b1;
         end
         RX_CAL: begin
            if (!rx_cal_busy) begin
               state_nx = RX_LTD;
               cnt_nx   = LTD_LOAD;
            end
         end
         RX_LTD: begin
            if (rx_cal_busy) begin
               state_nx = RX_RST;
               cnt_nx   = ANA_LOAD;
            end else if (!rx_ltd) begin
               cnt_nx   = LTD_LOAD;
            end else if (cnt == '0) begin
               state_nx = RX_READY;
            end else begin
               cnt_nx   = cnt - 1'b1;
            end
         end
         RX_READY: begin
            if (rx_cal_busy) begin
               state_nx = RX_RST;
               cnt_nx   = ANA_LOAD;
            end else if (!rx_ltd) begin
               state_nx = RX_LTD;
               cnt_nx   = LTD_LOAD;
            end
         end
         default: begin
            state_nx = RX_RST;
            cnt_nx   = ANA_LOAD;
         end
      endcase
   end

endmodule

// File: rtl/gx_reset_ctrl.sv
// Transceiver reset sequencer: group-wide TX/PLL FSM plus one RX FSM per lane.
//  state     | meaning
//  TX_PD     | PLL powered down for PLL_PD_CNT cycles
//  TX_WAIT   | PLL up, TX analog+digital held until hold time, lock and no cal
//  TX_ANALOG | TX analog released, digital held for TX_DIG_CNT cycles
//  TX_READY  | TX path out of reset
module gx_reset_ctrl
   import gx_reset_pkg::*;
#(
   parameter int CH_N       = 1,
   parameter int PLL_PD_CNT = DEF_PLL_PD_CNT,
   parameter int ANALOG_CNT = DEF_ANALOG_CNT,
   parameter int TX_DIG_CNT = DEF_TX_DIG_CNT,
   parameter int LTD_CNT    = DEF_LTD_CNT
) (
   input logic        clk_50m,
   input logic        io_nreset_i,
   gx_reset_if.master gx
);
   localparam int SW     = 2 + 3 * CH_N;
   localparam int TX_MAX = (PLL_PD_CNT > ANALOG_CNT)
                           ? ((PLL_PD_CNT > TX_DIG_CNT) ? PLL_PD_CNT : TX_DIG_CNT)
                           : ((ANALOG_CNT > TX_DIG_CNT) ? ANALOG_CNT : TX_DIG_CNT);
   localparam int TXW    = cnt_w(TX_MAX);
   localparam logic [TXW-1:0] PD_LOAD  = TXW'(PLL_PD_CNT - 1);
   localparam logic [TXW-1:0] ANA_LOAD = TXW'(ANALOG_CNT - 1);
   localparam logic [TXW-1:0] DIG_LOAD = TXW'(TX_DIG_CNT - 1);

   logic [SW-1:0]   sync_d, sync_q1, sync_q2;
   logic            pll_locked_s, pll_cal_busy_s;
   logic [CH_N-1:0] tx_cal_s, rx_cal_s, rx_ltd_s;
   logic            tx_cal_any, tx_ok;

   assign sync_d = {gx.pll_locked_i, gx.pll_cal_busy_i, gx.gx_tx_cal_busy_i,
                    gx.gx_rx_cal_busy_i, gx.gx_rx_is_lockedtodata_i};

   always_ff @(posedge clk_50m) begin
      if (!io_nreset_i) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= sync_d;
         sync_q2 <= sync_q1;
      end
   end

   assign {pll_locked_s, pll_cal_busy_s, tx_cal_s, rx_cal_s, rx_ltd_s} = sync_q2;
   assign tx_cal_any = pll_cal_busy_s | (|tx_cal_s);
   assign tx_ok      = pll_locked_s & ~tx_cal_any;

   tx_state_t       tx_state, tx_state_nx;
   logic [TXW-1:0]  tx_cnt, tx_cnt_nx;
   logic            pll_pd_q, tx_ana_q, tx_dig_q, tx_ready_q;

   always_ff @(posedge clk_50m) begin
      if (!io_nreset_i) begin
         tx_state   <= TX_PD;
         tx_cnt     <= PD_LOAD;
         pll_pd_q   <= 1'b1;
         tx_ana_q   <= 1'b1;
         tx_dig_q   <= 1'b1;
         tx_ready_q <= 1'b0;
      end else begin
         tx_state   <= tx_state_nx;
         tx_cnt     <= tx_cnt_nx;
         pll_pd_q   <= (tx_state_nx == TX_PD);
         tx_ana_q   <= (tx_state_nx == TX_PD) || (tx_state_nx == TX_WAIT);
         tx_dig_q   <= (tx_state_nx != TX_READY);
         tx_ready_q <= (tx_state_nx == TX_READY);
      end
   end

   always_comb begin
      tx_state_nx = tx_state;
      tx_cnt_nx   = tx_cnt;
      case (tx_state)
         TX_PD: begin
            if (tx_cnt == '0) begin
               tx_state_nx = TX_WAIT;
               tx_cnt_nx   = ANA_LOAD;
            end else begin
               tx_cnt_nx   = tx_cnt - 1'b1;
            end
         end
         TX_WAIT: begin
            if (tx_cnt != '0) begin
               tx_cnt_nx   = tx_cnt - 1'b1;
            end else if (tx_ok) begin
               tx_state_nx = TX_ANALOG;
               tx_cnt_nx   = DIG_LOAD;
            end
         end
         TX_ANALOG: begin
            if (!tx_ok) begin
               tx_state_nx = TX_WAIT;
               tx_cnt_nx   = ANA_LOAD;
            end else if (tx_cnt == '0) begin
               tx_state_nx = TX_READY;
            end else begin
               tx_cnt_nx   = tx_cnt - 1'b1;
            end
         end
         TX_READY: begin
            if (!tx_ok) begin
               tx_state_nx = TX_WAIT;
               tx_cnt_nx   = ANA_LOAD;
            end
         end
         default: begin
            tx_state_nx = TX_PD;
            tx_cnt_nx   = PD_LOAD;
         end
      endcase
   end

   assign gx.pll_powerdown_o      = pll_pd_q;
   assign gx.gx_tx_analogreset_o  = {CH_N{tx_ana_q}};
   assign gx.gx_tx_digitalreset_o = {CH_N{tx_dig_q}};
   assign gx.tx_ready_o           = tx_ready_q;

   logic [CH_N-1:0] rx_ana, rx_dig, rx_rdy;

   for (genvar i = 0; i < CH_N; i++) begin : g_rx
      gx_rx_reset_fsm #(
         .ANALOG_CNT (ANALOG_CNT),
         .LTD_CNT    (LTD_CNT)
      ) u_rx_fsm (
         .clk_50m         (clk_50m),
         .io_nreset_i     (io_nreset_i),
         .rx_cal_busy     (rx_cal_s[i]),
         .rx_ltd          (rx_ltd_s[i]),
         .rx_analogreset  (rx_ana[i]),
         .rx_digitalreset (rx_dig[i]),
         .rx_ready        (rx_rdy[i])
      );
   end

   assign gx.gx_rx_analogreset_o  = rx_ana;
   assign gx.gx_rx_digitalreset_o = rx_dig;
   assign gx.rx_ready_o           = rx_rdy;

endmodule

// File: tb/tb_gx_reset_ctrl.sv
// Scenario bench for gx_reset_ctrl (CH_N=4) against a phase/age reference model.
module tb_gx_reset_ctrl;
   localparam int CH = 4;
   localparam int PD = 10;
   localparam int AN = 4;
   localparam int TD = 8;
   localparam int LT = 16;
   localparam logic [21:0] RST_VEC = {1'b1, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF, 4'h0};

   logic clk;
   logic nrst;
   int   n_tests = 0;
   int   n_fail  = 0;

   gx_reset_if #(.CH_N(CH)) gx ();

   gx_reset_ctrl #(.CH_N(CH)) dut (
      .clk_50m     (clk),
      .io_nreset_i (nrst),
      .gx          (gx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic          lock;
      logic          pcal;
      logic [CH-1:0] txc;
      logic [CH-1:0] rxc;
      logic [CH-1:0] ltd;
   } stat_t;

   // Model: phase 0..3 in sequence order, age = cycles already spent in the phase,
   // streak = consecutive lock-to-data samples; status is seen two edges late.
   stat_t d1, d2;
   int    tx_ph, tx_age;
   int    rx_ph[CH], rx_age[CH], rx_streak[CH];

   function automatic stat_t now_in();
      stat_t s;
      s.lock = gx.pll_locked_i;
      s.pcal = gx.pll_cal_busy_i;
      s.txc  = gx.gx_tx_cal_busy_i;
      s.rxc  = gx.gx_rx_cal_busy_i;
      s.ltd  = gx.gx_rx_is_lockedtodata_i;
      return s;
   endfunction

   function automatic void model_edge();
      stat_t seen;
      bit    ok;
      seen = d2;
      if (!nrst) begin
         tx_ph = 0; tx_age = 0;
         for (int i = 0; i < CH; i++) begin
            rx_ph[i] = 0; rx_age[i] = 0; rx_streak[i] = 0;
         end
         d1 = '0; d2 = '0;
      end else begin
         ok = seen.lock && !seen.pcal && (seen.txc == '0);
         case (tx_ph)
            0: if (tx_age + 1 >= PD) begin tx_ph = 1; tx_age = 0; end else tx_age++;
            1: if (tx_age + 1 >= AN && ok) begin tx_ph = 2; tx_age = 0; end else tx_age++;
            2: if (!ok) begin tx_ph = 1; tx_age = 0; end
               else if (tx_age + 1 >= TD) tx_ph = 3;
               else tx_age++;
            default: if (!ok) begin tx_ph = 1; tx_age = 0; end
         endcase
         for (int i = 0; i < CH; i++) begin
            case (rx_ph[i])
               0: if (rx_age[i] + 1 >= AN) rx_ph[i] = 1; else rx_age[i]++;
               1: if (!seen.rxc[i]) begin rx_ph[i] = 2; rx_streak[i] = 0; end
               2: if (seen.rxc[i]) begin rx_ph[i] = 0; rx_age[i] = 0; end
                  else if (seen.ltd[i]) begin
                     rx_streak[i]++;
                     if (rx_streak[i] >= LT) rx_ph[i] = 3;
                  end else rx_streak[i] = 0;
               default: if (seen.rxc[i]) begin rx_ph[i] = 0; rx_age[i] = 0; end
                        else if (!seen.ltd[i]) begin rx_ph[i] = 2; rx_streak[i] = 0; end
            endcase
         end
         d2 = d1;
         d1 = now_in();
      end
   endfunction

   function automatic logic [21:0] exp_vec();
      logic pd, ta, td, tr;
      logic [CH-1:0] ra, rd, rr;
      pd = (tx_ph == 0); ta = (tx_ph <= 1); td = (tx_ph != 3); tr = (tx_ph == 3);
      for (int i = 0; i < CH; i++) begin
         ra[i] = (rx_ph[i] <= 1); rd[i] = (rx_ph[i] != 3); rr[i] = (rx_ph[i] == 3);
      end
      return {pd, {CH{ta}}, {CH{td}}, tr, ra, rd, rr};
   endfunction

   function automatic logic [21:0] dut_vec();
      return {gx.pll_powerdown_o, gx.gx_tx_analogreset_o, gx.gx_tx_digitalreset_o,
              gx.tx_ready_o, gx.gx_rx_analogreset_o, gx.gx_rx_digitalreset_o, gx.rx_ready_o};
   endfunction

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      step();
      step();
      nrst = 1'b1;
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         n_tests++;
         if (dut_vec() !== RST_VEC) begin
            n_fail++;
            $display("FAIL reset_values c=%0d got=%h exp=%h", c, dut_vec(), RST_VEC);
         end
      end
      nrst = 1'b1;
   endtask

   task automatic test_powerup();
      int pd_f = -1, ta_f = -1, td_f = -1, tr_r = -1;
      for (int c = 1; c <= 40; c++) begin
         step();
         n_tests++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL powerup_model c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
         if (pd_f < 0 && !gx.pll_powerdown_o) pd_f = c;
         if (ta_f < 0 && !gx.gx_tx_analogreset_o[0]) ta_f = c;
         if (td_f < 0 && !gx.gx_tx_digitalreset_o[0]) td_f = c;
         if (tr_r < 0 && gx.tx_ready_o) tr_r = c;
      end
      n_tests++;
      if (pd_f != PD) begin n_fail++; $display("FAIL pd_fall got=%0d exp=%0d", pd_f, PD); end
      n_tests++;
      if (ta_f != PD + AN) begin n_fail++; $display("FAIL tx_ana_fall got=%0d exp=%0d", ta_f, PD + AN); end
      n_tests++;
      if (td_f != PD + AN + TD) begin n_fail++; $display("FAIL tx_dig_fall got=%0d exp=%0d", td_f, PD + AN + TD); end
      n_tests++;
      if (tr_r != PD + AN + TD) begin n_fail++; $display("FAIL tx_ready_rise got=%0d exp=%0d", tr_r, PD + AN + TD); end
   endtask

   task automatic test_tx_gating();
      int ta_r = -1, ta_f = -1, rdy_f = -1;
      bit ta_dropped = 0;
      bit res_ok = 0;
      gx.pll_cal_busy_i = 1'b1;
      for (int c = 1; c <= 100; c++) begin
         step();
         n_tests++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL calbusy_model c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
         if (ta_r < 0 && gx.gx_tx_analogreset_o[0]) ta_r = c;
         if (ta_r >= 0 && !gx.gx_tx_analogreset_o[0]) ta_dropped = 1;
      end
      gx.pll_cal_busy_i = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         step();
         n_tests++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL calrel_model c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
         if (ta_f < 0 && !gx.gx_tx_analogreset_o[0]) ta_f = c;
      end
      n_tests++;
      if (ta_r != 3 || ta_dropped) begin
         n_fail++;
         $display("FAIL calbusy_hold rise=%0d dropped=%0d exp rise=3 dropped=0", ta_r, ta_dropped);
      end
      n_tests++;
      if (ta_f != 3) begin n_fail++; $display("FAIL calrel_fall got=%0d exp=3", ta_f); end
      gx.pll_locked_i = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         step();
         n_tests++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL lockloss_model c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
         if (rdy_f < 0 && !gx.tx_ready_o) begin
            rdy_f = c;
            res_ok = (gx.gx_tx_analogreset_o == 4'hF) && (gx.gx_tx_digitalreset_o == 4'hF);
         end
      end
      n_tests++;
      if (rdy_f != 3 || !res_ok) begin
         n_fail++;
         $display("FAIL lockloss_drop at=%0d resets_ok=%0d exp at=3 resets_ok=1", rdy_f, res_ok);
      end
      gx.pll_locked_i = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         step();
         n_tests++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL relock_model c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_rx_lock();
      int rise[CH];
      int start;
      for (int i = 0; i < CH; i++) rise[i] = -1;
      gx.gx_rx_is_lockedtodata_i = '0;
      do_reset();
      for (int c = 1; c <= 90; c++) begin
         for (int i = 0; i < CH; i++) gx.gx_rx_is_lockedtodata_i[i] = (c >= ((i == 2) ? 50 : 20));
         step();
         n_tests++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL rxlock_model c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
         for (int i = 0; i < CH; i++) if (rise[i] < 0 && gx.rx_ready_o[i]) rise[i] = c;
      end
      // first visible sample lands 2 edges after the input; ready on the 16th sample
      for (int i = 0; i < CH; i++) begin
         start = (i == 2) ? 50 : 20;
         n_tests++;
         if (rise[i] != start + 2 + LT - 1) begin
            n_fail++;
            $display("FAIL rxlock_lane%0d got=%0d exp=%0d", i, rise[i], start + 2 + LT - 1);
         end
      end
   endtask

   task automatic test_rx_glitch();
      int r1 = -1, f0 = -1, r2 = -1, l1 = -1;
      gx.gx_rx_is_lockedtodata_i = '1;
      do_reset();
      for (int c = 1; c <= 80; c++) begin
         gx.gx_rx_is_lockedtodata_i[0] = !(c == 15 || c == 45);
         step();
         n_tests++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL glitch_model c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
         if (r1 < 0 && gx.rx_ready_o[0]) r1 = c;
         else if (r1 >= 0 && f0 < 0 && !gx.rx_ready_o[0]) f0 = c;
         else if (f0 >= 0 && r2 < 0 && gx.rx_ready_o[0]) r2 = c;
         if (l1 < 0 && gx.rx_ready_o[1]) l1 = c;
         if (c == 47) begin
            n_tests++;
            if ({gx.rx_ready_o[0], gx.gx_rx_digitalreset_o[0], gx.gx_rx_analogreset_o[0]} !== 3'b010) begin
               n_fail++;
               $display("FAIL glitch_ready_outs got rdy/dig/ana=%b exp=010",
                        {gx.rx_ready_o[0], gx.gx_rx_digitalreset_o[0], gx.gx_rx_analogreset_o[0]});
            end
         end
      end
      n_tests++;
      if (l1 != AN + 1 + LT) begin n_fail++; $display("FAIL glitch_lane1 got=%0d exp=%0d", l1, AN + 1 + LT); end
      n_tests++;
      if (r1 != 15 + 2 + LT) begin n_fail++; $display("FAIL glitch_ltd_restart got=%0d exp=%0d", r1, 15 + 2 + LT); end
      n_tests++;
      if (f0 != 47 || r2 != 47 + LT) begin
         n_fail++;
         $display("FAIL glitch_in_ready fall=%0d rise=%0d exp fall=47 rise=%0d", f0, r2, 47 + LT);
      end
   endtask

   task automatic test_priority();
      for (int c = 1; c <= 30; c++) begin
         gx.gx_rx_cal_busy_i[1]        = (c == 5);
         gx.gx_rx_is_lockedtodata_i[1] = (c != 5);
         step();
         n_tests++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL prio_model c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
         if (c == 7) begin
            n_tests++;
            if (gx.gx_rx_analogreset_o[1] !== 1'b1 || gx.rx_ready_o[1] !== 1'b0) begin
               n_fail++;
               $display("FAIL prio_cal_wins ana=%b rdy=%b exp ana=1 rdy=0",
                        gx.gx_rx_analogreset_o[1], gx.rx_ready_o[1]);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      int pd_f = -1;
      do_reset();
      for (int c = 1; c <= 17; c++) begin
         step();
         n_tests++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL midrst_pre c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
      end
      nrst = 1'b0;
      step();
      n_tests++;
      if (dut_vec() !== RST_VEC) begin
         n_fail++;
         $display("FAIL midrst_values got=%h exp=%h", dut_vec(), RST_VEC);
      end
      nrst = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         step();
         n_tests++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL midrst_post c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
         if (pd_f < 0 && !gx.pll_powerdown_o) pd_f = c;
      end
      n_tests++;
      if (pd_f != PD) begin n_fail++; $display("FAIL midrst_pd_fall got=%0d exp=%0d", pd_f, PD); end
   endtask

   task automatic test_random();
      for (int c = 1; c <= 3000; c++) begin
         nrst = ($urandom_range(0, 999) != 0);
         if (gx.pll_locked_i) begin
            if ($urandom_range(0, 299) == 0) gx.pll_locked_i = 1'b0;
         end else if ($urandom_range(0, 9) == 0) gx.pll_locked_i = 1'b1;
         if (gx.pll_cal_busy_i) begin
            if ($urandom_range(0, 7) == 0) gx.pll_cal_busy_i = 1'b0;
         end else if ($urandom_range(0, 399) == 0) gx.pll_cal_busy_i = 1'b1;
         for (int i = 0; i < CH; i++) begin
            if (gx.gx_tx_cal_busy_i[i]) begin
               if ($urandom_range(0, 7) == 0) gx.gx_tx_cal_busy_i[i] = 1'b0;
            end else if ($urandom_range(0, 799) == 0) gx.gx_tx_cal_busy_i[i] = 1'b1;
            if (gx.gx_rx_cal_busy_i[i]) begin
               if ($urandom_range(0, 7) == 0) gx.gx_rx_cal_busy_i[i] = 1'b0;
            end else if ($urandom_range(0, 299) == 0) gx.gx_rx_cal_busy_i[i] = 1'b1;
            if ($urandom_range(0, 31) == 0)
               gx.gx_rx_is_lockedtodata_i[i] = ~gx.gx_rx_is_lockedtodata_i[i];
         end
         step();
         n_tests++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL random_model c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
      end
      nrst = 1'b1;
   endtask

   initial begin
      nrst                       = 1'b0;
      gx.pll_locked_i            = 1'b1;
      gx.pll_cal_busy_i          = 1'b0;
      gx.gx_tx_cal_busy_i        = '0;
      gx.gx_rx_cal_busy_i        = '0;
      gx.gx_rx_is_lockedtodata_i = '0;
      test_reset();
      test_powerup();
      test_tx_gating();
      test_rx_lock();
      test_rx_glitch();
      test_priority();
      test_mid_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
